// File: rtl/coin_return_dispenser_if.sv
// Coin return dispenser bus: refund requests, vend pulse, inventory load,
// hopper handshake and status outputs.
interface coin_return_dispenser_if;
  logic [2:0]  return_coin;
  logic        product;
  logic        load_en;
  logic [7:0]  load_ones;
  logic [7:0]  load_twos;
  logic        eject_done;
  logic        clear_fault;
  logic        eject_one;
  logic        eject_two;
  logic        vend_motor;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic        short_change;
  logic        fault;
  logic [7:0]  ones_left;
  logic [7:0]  twos_left;
  logic [15:0] refund_total;

  modport master (
    output return_coin, product, load_en, load_ones, load_twos,
    output eject_done, clear_fault,
    input  eject_one, eject_two, vend_motor, busy, fifo_full,
    input  overflow, short_change, fault, ones_left, twos_left,
    input  refund_total
  );

  modport slave (
    input  return_coin, product, load_en, load_ones, load_twos,
    input  eject_done, clear_fault,
    output eject_one, eject_two, vend_motor, busy, fifo_full,
    output overflow, short_change, fault, ones_left, twos_left,
    output refund_total
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// Coin return dispenser: refund FIFO, hopper eject FSM and vend motor timer.
// Optional refund statistics counter enabled by DISPENSER_STATS_EN.
module coin_return_dispenser #(
  parameter int FIFO_DEPTH    = 4,
  parameter int EJECT_TIMEOUT = 15,
  parameter int VEND_CYCLES   = 8
) (
  input logic clk,
  input logic reset,
  coin_return_dispenser_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(EJECT_TIMEOUT + 1);
  localparam int VW = $clog2(VEND_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SELECT,
    S_WAIT2,
    S_WAIT1,
    S_FAULT
  } state_t;

  state_t r_state, w_next;

  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_rem, w_rem_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]    r_ones, r_twos;
  logic [VW-1:0] r_vend;
  logic          r_ovf, r_short, r_fault;

  logic w_req, w_full, w_empty, w_push, w_pop;
  logic w_zero, w_can2, w_can1, w_none;
  logic w_ej1, w_ej2, w_dec1, w_dec2;
  logic w_set_short, w_set_fault, w_clr_fault;

  assign w_req   = |bus.return_coin;
  assign w_full  = r_cnt == CW'(FIFO_DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_push  = w_req && !w_full;
  assign w_pop   = r_state == S_LOAD;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= bus.return_coin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Mutually exclusive SELECT outcomes, in priority order
  assign w_zero = r_rem == 3'd0;
  assign w_can2 = !w_zero && r_rem >= 3'd2 && r_twos != 8'd0;
  assign w_can1 = !w_zero && !w_can2 && r_ones != 8'd0;
  assign w_none = !w_zero && !w_can2 && !w_can1;

  always_comb begin
    w_next      = r_state;
    w_rem_nxt   = r_rem;
    w_tmo_nxt   = r_tmo;
    w_ej1       = 1'b0;
    w_ej2       = 1'b0;
    w_dec1      = 1'b0;
    w_dec2      = 1'b0;
    w_set_short = 1'b0;
    w_set_fault = 1'b0;
    w_clr_fault = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty || w_push) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_rem_nxt = r_mem[r_rd];
        w_next    = S_SELECT;
      end
      S_SELECT: begin
        w_tmo_nxt = '0;
        unique case (1'b1)
          w_zero: w_next = S_IDLE;
          w_can2: begin
            w_ej2  = 1'b1;
            w_next = S_WAIT2;
          end
          w_can1: begin
            w_ej1  = 1'b1;
            w_next = S_WAIT1;
          end
          w_none: begin
            w_set_short = 1'b1;
            w_rem_nxt   = 3'd0;
            w_next      = S_IDLE;
          end
          default: w_next = S_IDLE;
        endcase
      end
      S_WAIT2, S_WAIT1: begin
        if (bus.eject_done) begin
          w_dec2    = r_state == S_WAIT2;
          w_dec1    = r_state == S_WAIT1;
          w_rem_nxt = r_rem - (w_dec2 ? 3'd2 : 3'd1);
          w_next    = S_SELECT;
        end else if (r_tmo == TW'(EJECT_TIMEOUT - 1)) begin
          w_set_fault = 1'b1;
          w_next      = S_FAULT;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_FAULT: begin
        if (bus.clear_fault) begin
          w_clr_fault = 1'b1;
          w_rem_nxt   = 3'd0;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_tmo   <= '0;
      r_ovf   <= 1'b0;
      r_short <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rem   <= w_rem_nxt;
      r_tmo   <= w_tmo_nxt;
      r_ovf   <= r_ovf | (w_req && w_full);
      r_short <= r_short | w_set_short;
      if (w_set_fault)      r_fault <= 1'b1;
      else if (w_clr_fault) r_fault <= 1'b0;
    end
  end

  // A load strobe overrides any coincident decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ones <= '0;
      r_twos <= '0;
    end else if (bus.load_en) begin
      r_ones <= bus.load_ones;
      r_twos <= bus.load_twos;
    end else begin
      if (w_dec1 && r_ones != 8'd0) r_ones <= r_ones - 8'd1;
      if (w_dec2 && r_twos != 8'd0) r_twos <= r_twos - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vend <= '0;
    end else if (bus.product) begin
      r_vend <= VW'(VEND_CYCLES);
    end else if (r_vend != '0) begin
      r_vend <= r_vend - VW'(1);
    end
  end

`ifdef DISPENSER_STATS_EN
  logic [15:0] r_total;
  logic [16:0] w_sum;

  assign w_sum = {1'b0, r_total}
               + (w_dec2 ? 17'd2 : (w_dec1 ? 17'd1 : 17'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_total <= '0;
    else       r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign bus.refund_total = r_total;
`else
  assign bus.refund_total = '0;
`endif

  assign bus.eject_one    = w_ej1;
  assign bus.eject_two    = w_ej2;
  assign bus.vend_motor   = r_vend != '0;
  assign bus.busy         = (r_state != S_IDLE) || !w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.overflow     = r_ovf;
  assign bus.short_change = r_short;
  assign bus.fault        = r_fault;
  assign bus.ones_left    = r_ones;
  assign bus.twos_left    = r_twos;
endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: queue-based refund model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_coin_return_dispenser;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam int VEND  = 8;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_SEL   = 2;
  localparam int P_W2    = 3;
  localparam int P_W1    = 4;
  localparam int P_FAULT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  coin_return_dispenser_if bus();

  coin_return_dispenser #(
    .FIFO_DEPTH(DEPTH),
    .EJECT_TIMEOUT(TMO),
    .VEND_CYCLES(VEND)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int q[$];
  int m_ph, m_rem, m_tmo, m_ones, m_twos, m_vend, m_total;
  bit m_ovf, m_short, m_fault;

  int total = 0;
  int bad = 0;
  int ack_delay = -1;
  bit force_done = 0;
  bit load_on_ack = 0;
  int n1, n2, nv;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ej2();
    return m_ph == P_SEL && m_rem >= 2 && m_twos > 0;
  endfunction

  function automatic bit m_ej1();
    return m_ph == P_SEL && !m_ej2() && m_rem >= 1 && m_ones > 0;
  endfunction

  function automatic bit m_waiting();
    return m_ph == P_W2 || m_ph == P_W1;
  endfunction

  task automatic m_reset();
    q.delete();
    m_ph = P_IDLE;
    m_rem = 0;
    m_tmo = 0;
    m_ones = 0;
    m_twos = 0;
    m_vend = 0;
    m_total = 0;
    m_ovf = 0;
    m_short = 0;
    m_fault = 0;
  endtask

  task automatic m_step();
    bit req, full, push;
    int nph, c;
    req  = bus.return_coin != 0;
    full = q.size() == DEPTH;
    push = req && !full;
    nph  = m_ph;
    if (req && full) m_ovf = 1;
    case (m_ph)
      P_IDLE: if (q.size() > 0 || push) nph = P_LOAD;
      P_LOAD: begin
        m_rem = q.pop_front();
        nph = P_SEL;
      end
      P_SEL: begin
        m_tmo = 0;
        if (m_rem == 0) nph = P_IDLE;
        else if (m_ej2()) nph = P_W2;
        else if (m_ej1()) nph = P_W1;
        else begin
          m_short = 1;
          m_rem = 0;
          nph = P_IDLE;
        end
      end
      P_W2, P_W1: begin
        c = (m_ph == P_W2) ? 2 : 1;
        if (bus.eject_done) begin
          m_rem -= c;
          m_total = (m_total + c > 65535) ? 65535 : m_total + c;
          if (c == 2 && m_twos > 0) m_twos--;
          if (c == 1 && m_ones > 0) m_ones--;
          nph = P_SEL;
        end else if (m_tmo == TMO - 1) begin
          m_fault = 1;
          nph = P_FAULT;
        end else begin
          m_tmo++;
        end
      end
      P_FAULT: if (bus.clear_fault) begin
        m_fault = 0;
        m_rem = 0;
        nph = P_IDLE;
      end
      default: nph = P_IDLE;
    endcase
    if (push) q.push_back(int'(bus.return_coin));
    if (bus.load_en) begin
      m_ones = bus.load_ones;
      m_twos = bus.load_twos;
    end
    if (bus.product) m_vend = VEND;
    else if (m_vend > 0) m_vend--;
    m_ph = nph;
  endtask

  task automatic compare_all();
    check("eject_one", bus.eject_one, m_ej1());
    check("eject_two", bus.eject_two, m_ej2());
    check("vend_motor", bus.vend_motor, m_vend > 0);
    check("busy", bus.busy, m_ph != P_IDLE || q.size() > 0);
    check("fifo_full", bus.fifo_full, q.size() == DEPTH);
    check("overflow", bus.overflow, m_ovf);
    check("short_change", bus.short_change, m_short);
    check("fault", bus.fault, m_fault);
    check("ones_left", bus.ones_left, m_ones);
    check("twos_left", bus.twos_left, m_twos);
`ifdef DISPENSER_STATS_EN
    check("refund_total", bus.refund_total, m_total);
`else
    check("refund_total", bus.refund_total, 0);
`endif
  endtask

  task automatic cyc();
    bus.eject_done = force_done ||
                     (m_waiting() && m_tmo == ack_delay);
    if (load_on_ack && bus.eject_done && m_waiting())
      bus.load_en = 1'b1;
    #1;
    if (!reset) compare_all();
    if (bus.eject_one === 1'b1) n1++;
    if (bus.eject_two === 1'b1) n2++;
    if (bus.vend_motor === 1'b1) nv++;
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    @(negedge clk);
    if (load_on_ack) bus.load_en = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic req(int v);
    bus.return_coin = 3'(v);
    cyc();
    bus.return_coin = '0;
  endtask

  task automatic load(int a, int b);
    bus.load_ones = 8'(a);
    bus.load_twos = 8'(b);
    bus.load_en = 1'b1;
    cyc();
    bus.load_en = 1'b0;
  endtask

  initial begin
    bus.return_coin = '0;
    bus.product = 0;
    bus.load_en = 0;
    bus.load_ones = '0;
    bus.load_twos = '0;
    bus.eject_done = 0;
    bus.clear_fault = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ones", bus.ones_left, 0);
    check("rst_vend", bus.vend_motor, 0);
    check("rst_total", bus.refund_total, 0);
    reset = 1'b0;
    idle(2);

    // 5 rupees from 5/5 inventory: 2 + 2 + 1
    load(5, 5);
    ack_delay = 1;
    n1 = 0;
    n2 = 0;
    req(5);
    idle(20);
    check("r5_n2", n2, 2);
    check("r5_n1", n1, 1);
    check("r5_ones", bus.ones_left, 4);
    check("r5_twos", bus.twos_left, 3);
`ifdef DISPENSER_STATS_EN
    check("r5_total", bus.refund_total, 5);
`endif

    // Short change: 4 rupees from three ones only
    load(3, 0);
    n1 = 0;
    req(4);
    idle(25);
    check("sc_n1", n1, 3);
    check("sc_flag", bus.short_change, 1);
    check("sc_ones", bus.ones_left, 0);

    // Stray hopper pulse while idle
    force_done = 1;
    cyc();
    force_done = 0;
    idle(2);

    // Load strobe coinciding with a decrement
    load(2, 2);
    bus.load_ones = 8'd9;
    bus.load_twos = 8'd9;
    load_on_ack = 1;
    req(2);
    idle(10);
    load_on_ack = 0;
    check("lw_twos", bus.twos_left, 9);
    check("lw_ones", bus.ones_left, 9);

    // Overflow while stalled in WAIT2, then timeout fault
    load(5, 5);
    ack_delay = -1;
    req(2);
    idle(3);
    for (int i = 0; i < 5; i++) req(1);
    check("ov_full", bus.fifo_full, 1);
    check("ov_flag", bus.overflow, 1);
    idle(15);
    check("to_fault", bus.fault, 1);
    n1 = 0;
    n2 = 0;
    idle(5);
    check("to_noeject", n1 + n2, 0);
    bus.clear_fault = 1;
    cyc();
    bus.clear_fault = 0;
    ack_delay = 0;
    idle(30);
    check("cf_fault", bus.fault, 0);
    check("cf_ones", bus.ones_left, 1);
    check("cf_twos", bus.twos_left, 5);
    check("cf_busy", bus.busy, 0);

    // Retriggered vend alongside a refund
    nv = 0;
    bus.product = 1;
    bus.return_coin = 3'd3;
    cyc();
    bus.product = 0;
    bus.return_coin = '0;
    idle(3);
    bus.product = 1;
    cyc();
    bus.product = 0;
    idle(15);
    check("vend_len", nv, 12);
    check("vend_twos", bus.twos_left, 4);
    check("vend_ones", bus.ones_left, 0);

    // Reset while waiting in WAIT1 with two queued requests
    ack_delay = -1;
    load(5, 5);
    req(1);
    idle(2);
    req(1);
    req(1);
    reset = 1'b1;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_full", bus.fifo_full, 0);
    check("ar_ones", bus.ones_left, 0);
    check("ar_ej1", bus.eject_one, 0);
    check("ar_ovf", bus.overflow, 0);
    cyc();
    reset = 1'b0;
    idle(4);
    check("ar_busy2", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
